// File: rtl/game_io_pkg.sv
// Shared encodings for the game register controller and the PS/2 key handshake.
package game_io_pkg;

  localparam logic [1:0] GS_TITLE = 2'd0;
  localparam logic [1:0] GS_PLAY  = 2'd1;
  localparam logic [1:0] GS_OVER  = 2'd2;

  localparam logic [1:0] KEY_NONE    = 2'd0;
  localparam logic [1:0] KEY_PRESS   = 2'd1;
  localparam logic [1:0] KEY_RELEASE = 2'd2;

  localparam logic [1:0] KS_IDLE     = 2'd0;
  localparam logic [1:0] KS_ACK      = 2'd1;
  localparam logic [1:0] KS_WAIT_CLR = 2'd2;

  localparam int unsigned SCORE_MAX_DEFAULT = 9999;

  // True when a processor write carries a defined game state encoding.
  function automatic logic is_legal_game_state(input logic [31:0] value);
    return value <= {30'd0, GS_OVER};
  endfunction

endpackage

// File: rtl/ps2_key_handshake.sv
// PS/2 space-key acknowledge FSM: accepts one event, holds the acknowledge for
// ACK_HOLD cycles, then waits for the PS/2 side to drop its event code.
module ps2_key_handshake
  import game_io_pkg::*;
#(
  parameter int ACK_HOLD = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] space_state_i,
  output logic       key_press_o,
  output logic       reset_space_state_o
);

  localparam int CW = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(ACK_HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Events seen outside IDLE are dropped on purpose; this is the debounce.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_press_o = 1'b0;
    case (state_q)
      KS_IDLE: begin
        cnt_d = '0;
        if (space_state_i == KEY_PRESS) begin
          state_d     = KS_ACK;
          key_press_o = ~reset_i;
        end else if (space_state_i == KEY_RELEASE) begin
          state_d = KS_ACK;
        end
      end
      KS_ACK: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = KS_WAIT_CLR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      KS_WAIT_CLR: begin
        if (space_state_i == KEY_NONE) begin
          state_d = KS_IDLE;
        end
      end
      default: begin
        state_d = KS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reset_space_state_o = (state_q != KS_IDLE);

endmodule

// File: rtl/game_reg_controller.sv
// Game-visible register file (game_state, bird_y, score) with write checking,
// reseed pulse and PS/2 key tracking. GAME_AUTO_START_EN lets key presses advance game_state.
module game_reg_controller
  import game_io_pkg::*;
#(
  parameter int unsigned SCORE_MAX  = SCORE_MAX_DEFAULT,
  parameter int          BIRD_Y_MIN = -32,
  parameter int          BIRD_Y_MAX = 447,
  parameter int          ACK_HOLD   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        w_game_state,
  input  logic        w_bird_y,
  input  logic        w_score,
  input  logic [31:0] val_out,
  input  logic        key_clr,
  input  logic [1:0]  space_state,
  output logic        reset_space_state,
  output logic [1:0]  game_state,
  output logic [31:0] bird_y,
  output logic [31:0] score,
  output logic        random_reset,
  output logic        key_press,
  output logic        key_pending,
  output logic        write_err
);

  localparam logic [31:0] SCORE_MAX_V  = 32'(SCORE_MAX);
  localparam logic [31:0] BIRD_Y_MIN_V = 32'(BIRD_Y_MIN);
  localparam logic [31:0] BIRD_Y_MAX_V = 32'(BIRD_Y_MAX);

  logic [1:0]  game_state_q, game_state_d;
  logic [31:0] bird_y_q, bird_y_d;
  logic [31:0] score_q, score_d;
  logic        random_reset_q, random_reset_d;
  logic        key_pending_q, key_pending_d;
  logic        write_err_q, write_err_d;
  logic        gs_write_ok;
  logic        score_clear;

  ps2_key_handshake #(
    .ACK_HOLD(ACK_HOLD)
  ) u_key (
    .clock_i            (clock),
    .reset_i            (reset),
    .space_state_i      (space_state),
    .key_press_o        (key_press),
    .reset_space_state_o(reset_space_state)
  );

  // A processor strobe always beats a hardware-initiated state change.
  always_comb begin
    gs_write_ok  = w_game_state && is_legal_game_state(val_out);
    game_state_d = game_state_q;
    write_err_d  = write_err_q;
    score_clear  = 1'b0;
    if (w_game_state) begin
      if (gs_write_ok) begin
        game_state_d = val_out[1:0];
      end else begin
        write_err_d = 1'b1;
      end
    end
`ifdef GAME_AUTO_START_EN
    else if (key_press) begin
      if (game_state_q == GS_TITLE) begin
        game_state_d = GS_PLAY;
      end else if (game_state_q == GS_OVER) begin
        game_state_d = GS_TITLE;
        score_clear  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    bird_y_d = bird_y_q;
    if (w_bird_y) begin
      if ($signed(val_out) < BIRD_Y_MIN) begin
        bird_y_d = BIRD_Y_MIN_V;
      end else if ($signed(val_out) > BIRD_Y_MAX) begin
        bird_y_d = BIRD_Y_MAX_V;
      end else begin
        bird_y_d = val_out;
      end
    end
  end

  always_comb begin
    score_d = score_q;
    if (w_score) begin
      score_d = (val_out > SCORE_MAX_V) ? SCORE_MAX_V : val_out;
    end else if (score_clear) begin
      score_d = '0;
    end
  end

  // A press in the same cycle as any clear source still leaves the key pending.
  always_comb begin
    key_pending_d = key_pending_q;
    if (key_clr || (gs_write_ok && (game_state_d != game_state_q))) begin
      key_pending_d = 1'b0;
    end
    if (key_press) begin
      key_pending_d = 1'b1;
    end
    random_reset_d = (game_state_q == GS_TITLE) && (game_state_d == GS_PLAY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      game_state_q   <= GS_TITLE;
      bird_y_q       <= '0;
      score_q        <= '0;
      random_reset_q <= 1'b0;
      key_pending_q  <= 1'b0;
      write_err_q    <= 1'b0;
    end else begin
      game_state_q   <= game_state_d;
      bird_y_q       <= bird_y_d;
      score_q        <= score_d;
      random_reset_q <= random_reset_d;
      key_pending_q  <= key_pending_d;
      write_err_q    <= write_err_d;
    end
  end

  assign game_state   = game_state_q;
  assign bird_y       = bird_y_q;
  assign score        = score_q;
  assign random_reset = random_reset_q;
  assign key_pending  = key_pending_q;
  assign write_err    = write_err_q;

endmodule

// File: tb/tb_game_reg_controller.sv
// Self-checking bench for game_reg_controller: per-cycle reference model plus
// directed literal checks. Define GAME_AUTO_START_EN to cover the auto-start build.
module tb_game_reg_controller;

  localparam int ACK_HOLD  = 8;
  localparam int SCORE_MAX = 9999;
  localparam int BMIN      = -32;
  localparam int BMAX      = 447;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        w_game_state = 1'b0;
  logic        w_bird_y = 1'b0;
  logic        w_score = 1'b0;
  logic [31:0] val_out = '0;
  logic        key_clr = 1'b0;
  logic [1:0]  space_state = 2'd0;
  logic        reset_space_state;
  logic [1:0]  game_state;
  logic [31:0] bird_y;
  logic [31:0] score;
  logic        random_reset;
  logic        key_press;
  logic        key_pending;
  logic        write_err;

  int checks = 0;
  int fails  = 0;
  bit checkEn = 1'b0;

  always #5 clock = ~clock;

  game_reg_controller #(
    .SCORE_MAX (SCORE_MAX),
    .BIRD_Y_MIN(BMIN),
    .BIRD_Y_MAX(BMAX),
    .ACK_HOLD  (ACK_HOLD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .w_game_state     (w_game_state),
    .w_bird_y         (w_bird_y),
    .w_score          (w_score),
    .val_out          (val_out),
    .key_clr          (key_clr),
    .space_state      (space_state),
    .reset_space_state(reset_space_state),
    .game_state       (game_state),
    .bird_y           (bird_y),
    .score            (score),
    .random_reset     (random_reset),
    .key_press        (key_press),
    .key_pending      (key_pending),
    .write_err        (write_err)
  );

  // Reference model state: registers as the spec describes them, plus the key
  // handshake tracked as "cycles of acknowledge left" and "waiting for release".
  logic [1:0]  mGs = '0;
  logic [31:0] mBird = '0;
  logic [31:0] mScore = '0;
  logic        mErr = 1'b0;
  logic        mPend = 1'b0;
  logic        mRr = 1'b0;
  int          mAckLeft = 0;
  bit          mWaitClr = 1'b0;
  logic        expPress;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic wgs, input logic wby, input logic wsc,
                               input logic [31:0] val, input logic clr, input logic [1:0] sp);
    w_game_state = wgs;
    w_bird_y     = wby;
    w_score      = wsc;
    val_out      = val;
    key_clr      = clr;
    space_state  = sp;
    tick();
    w_game_state = 1'b0;
    w_bird_y     = 1'b0;
    w_score      = 1'b0;
    val_out      = '0;
    key_clr      = 1'b0;
  endtask

  task automatic waitIdle();
    space_state = 2'd0;
    for (int i = 0; i < 40; i++) begin
      if (reset_space_state == 1'b0) break;
      tick();
    end
    checkOutput("handshake_idle", 32'(reset_space_state), 32'd0);
  endtask

  always @(posedge clock) begin : modelUpdate
    logic [1:0]  gsN;
    logic [31:0] scoreN;
    logic        errN;
    logic        pendN;
    int          v;
    bit          busy;
    bit          press;
    bit          evt;
    busy  = (mAckLeft > 0) || mWaitClr;
    press = !busy && (space_state == 2'd1);
    evt   = !busy && ((space_state == 2'd1) || (space_state == 2'd2));
    if (reset) begin
      mGs <= '0; mBird <= '0; mScore <= '0; mErr <= 1'b0;
      mPend <= 1'b0; mRr <= 1'b0; mAckLeft <= 0; mWaitClr <= 1'b0;
    end else begin
      gsN = mGs; errN = mErr; scoreN = mScore;
      if (w_game_state) begin
        if (val_out <= 32'd2) gsN = val_out[1:0];
        else errN = 1'b1;
      end
`ifdef GAME_AUTO_START_EN
      else if (press) begin
        if (mGs == 2'd0) gsN = 2'd1;
        else if (mGs == 2'd2) begin
          gsN = 2'd0;
          scoreN = 32'd0;
        end
      end
`endif
      if (w_score) scoreN = (val_out > 32'(SCORE_MAX)) ? 32'(SCORE_MAX) : val_out;
      if (w_bird_y) begin
        v = $signed(val_out);
        if (v < BMIN) v = BMIN;
        if (v > BMAX) v = BMAX;
        mBird <= 32'(v);
      end
      pendN = mPend;
      if (key_clr) pendN = 1'b0;
      if (w_game_state && (val_out <= 32'd2) && (gsN != mGs)) pendN = 1'b0;
      if (press) pendN = 1'b1;
      mGs    <= gsN;
      mErr   <= errN;
      mScore <= scoreN;
      mPend  <= pendN;
      mRr    <= (mGs == 2'd0) && (gsN == 2'd1);
      if (evt) begin
        mAckLeft <= ACK_HOLD;
      end else if (mAckLeft > 0) begin
        mAckLeft <= mAckLeft - 1;
        if (mAckLeft == 1) mWaitClr <= 1'b1;
      end else if (mWaitClr && (space_state == 2'd0)) begin
        mWaitClr <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      expPress = !reset && !((mAckLeft > 0) || mWaitClr) && (space_state == 2'd1);
      checkOutput("cyc_game_state", 32'(game_state), 32'(mGs));
      checkOutput("cyc_bird_y", bird_y, mBird);
      checkOutput("cyc_score", score, mScore);
      checkOutput("cyc_write_err", 32'(write_err), 32'(mErr));
      checkOutput("cyc_key_pending", 32'(key_pending), 32'(mPend));
      checkOutput("cyc_random_reset", 32'(random_reset), 32'(mRr));
      checkOutput("cyc_reset_space_state", 32'(reset_space_state), 32'((mAckLeft > 0) || mWaitClr));
      checkOutput("cyc_key_press", 32'(key_press), 32'(expPress));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int rssHigh;
    $display("[TB] start");
    // 1: reset and first write
    reset = 1'b1;
    repeat (3) @(posedge clock);
    checkEn = 1'b1;
    #1;
    checkOutput("rst_game_state", 32'(game_state), 32'd0);
    checkOutput("rst_bird_y", bird_y, 32'd0);
    checkOutput("rst_score", score, 32'd0);
    checkOutput("rst_rss", 32'(reset_space_state), 32'd0);
    checkOutput("rst_write_err", 32'(write_err), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd100, 1'b0, 2'd0);
    checkOutput("bird_y_100", bird_y, 32'd100);

    // 2: clamp, saturate, illegal state writes
    applyStimulus(1'b0, 1'b1, 1'b0, 32'(-100), 1'b0, 2'd0);
    checkOutput("bird_y_low_clamp", bird_y, 32'(-32));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1000, 1'b0, 2'd0);
    checkOutput("bird_y_high_clamp", bird_y, 32'd447);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'(-32), 1'b0, 2'd0);
    checkOutput("bird_y_min_exact", bird_y, 32'(-32));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd447, 1'b0, 2'd0);
    checkOutput("bird_y_max_exact", bird_y, 32'd447);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd12345, 1'b0, 2'd0);
    checkOutput("score_saturate", score, 32'd9999);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd9999, 1'b0, 2'd0);
    checkOutput("score_max_exact", score, 32'd9999);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd500, 1'b0, 2'd0);
    checkOutput("simul_bird_y", bird_y, 32'd447);
    checkOutput("simul_score", score, 32'd500);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 2'd0);
    checkOutput("gs3_unchanged", 32'(game_state), 32'd0);
    checkOutput("gs3_write_err", 32'(write_err), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 2'd0);
    checkOutput("gs_big_unchanged", 32'(game_state), 32'd0);

    // 3: reseed pulse on 0 -> 1 only
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 2'd0);
    checkOutput("gs_play", 32'(game_state), 32'd1);
    checkOutput("rr_pulse", 32'(random_reset), 32'd1);
    tick();
    checkOutput("rr_drop", 32'(random_reset), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 2'd0);
    checkOutput("rr_rewrite_none", 32'(random_reset), 32'd0);
    checkOutput("err_sticky", 32'(write_err), 32'd1);

    // 4: key handshake
    space_state = 2'd1;
    #1;
    checkOutput("key_press_comb", 32'(key_press), 32'd1);
    tick();
    rssHigh = 1;
    checkOutput("key_press_one_cycle", 32'(key_press), 32'd0);
    checkOutput("key_pending_set", 32'(key_pending), 32'd1);
    checkOutput("rss_high", 32'(reset_space_state), 32'd1);
    space_state = 2'd0;
    tick();
    if (reset_space_state) rssHigh++;
    space_state = 2'd1;
    #1;
    checkOutput("press_in_ack_ignored", 32'(key_press), 32'd0);
    tick();
    if (reset_space_state) rssHigh++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reset_space_state) rssHigh++;
    end
    checkOutput("rss_held_min", 32'(rssHigh >= ACK_HOLD), 32'd1);
    checkOutput("rss_wait_clr", 32'(reset_space_state), 32'd1);
    space_state = 2'd0;
    tick();
    checkOutput("rss_release", 32'(reset_space_state), 32'd0);

    // 5: key_pending set/clear interplay
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0);
    checkOutput("clr_alone", 32'(key_pending), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd1);
    checkOutput("clr_with_press", 32'(key_pending), 32'd1);
    waitIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0);
    checkOutput("clr_alone_again", 32'(key_pending), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 2'd0);
    checkOutput("gs_same_keeps_pending", 32'(key_pending), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 2'd0);
    checkOutput("gs_change_clears_pending", 32'(key_pending), 32'd0);
    checkOutput("gs_over", 32'(game_state), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd2);
    checkOutput("release_acks", 32'(reset_space_state), 32'd1);
    checkOutput("release_no_pending", 32'(key_pending), 32'd0);
    waitIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd3);
    checkOutput("code3_ignored", 32'(reset_space_state), 32'd0);
    space_state = 2'd0;

    // reset while waiting for release
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1);
    repeat (ACK_HOLD) tick();
    checkOutput("in_wait_clr", 32'(reset_space_state), 32'd1);
    reset = 1'b1;
    space_state = 2'd0;
    tick();
    checkOutput("reset_drops_rss", 32'(reset_space_state), 32'd0);
    checkOutput("reset_clears_err", 32'(write_err), 32'd0);
    checkOutput("reset_clears_score", score, 32'd0);
    reset = 1'b0;
    tick();

`ifdef GAME_AUTO_START_EN
    // 6: hardware auto-start
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1);
    checkOutput("auto_title_to_play", 32'(game_state), 32'd1);
    checkOutput("auto_rr_pulse", 32'(random_reset), 32'd1);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd42, 1'b0, 2'd0);
    checkOutput("auto_score_42", score, 32'd42);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1);
    checkOutput("auto_over_to_title", 32'(game_state), 32'd0);
    checkOutput("auto_score_cleared", score, 32'd0);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 2'd1);
    checkOutput("auto_strobe_priority", 32'(game_state), 32'd2);
    checkOutput("auto_strobe_no_rr", 32'(random_reset), 32'd0);
    checkOutput("auto_strobe_pending", 32'(key_pending), 32'd1);
    waitIdle();
`else
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1);
    checkOutput("press_no_auto_start", 32'(game_state), 32'd0);
    checkOutput("press_no_rr", 32'(random_reset), 32'd0);
    waitIdle();
`endif

    tick();
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
